// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter that time-shares one mux_4_1 among four requesters.
// Drives the mux selects, bounds owner hold time and inserts a one-cycle turnaround.
module mux_4_1_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       S_0,
    output logic       S_1,
    output logic       busy,
    output logic       preempt
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            preempt_q, preempt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [1:0]      win;
    logic [1:0]      idx;
    logic            found;
    logic            owner_req;
    logic            others;
    logic            preempt_hit;
    logic            revoke;

    // First requester in search order starting at ptr_q
    always_comb begin
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // The S lines double as the owner index while BUSY
    assign owner_req   = req[sel_q];
    assign others      = |(req & ~gnt_q);
    assign preempt_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && owner_req && others;
    assign revoke      = !owner_req || preempt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req)  state_d = BUSY;
            BUSY:    if (revoke) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d  = 4'b0001 << win;
                    sel_d  = win;
                    busy_d = 1'b1;
                    hold_d = '0;
                end
            end
            BUSY: begin
                hold_d = (hold_q != HOLD_MAX) ? hold_q + HW'(1) : hold_q;
                if (revoke) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + 2'd1;
                    // A dropping owner counts as release even if the hold limit hits too
                    preempt_d = owner_req;
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign S_0     = sel_q[0];
    assign S_1     = sel_q[1];
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
